// File: rtl/uart_io_bridge_pkg.sv
// Shared constants, state encodings and small helpers for the UART-to-I/O-bus debug bridge.
package uart_io_bridge_pkg;

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] RSP_K = 8'h4B;
   localparam logic [7:0] RSP_E = 8'h45;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_DATA_H,
      ST_DATA_L,
      ST_REQ,
      ST_ACCESS,
      ST_TX,
      ST_TX_GAP
   } state_t;

   // Which reply byte the TX sequencer sends next.
   typedef enum logic [1:0] {
      SEL_K,
      SEL_E,
      SEL_HI,
      SEL_LO
   } tx_sel_t;

   function automatic logic is_rx_state(input state_t s);
      return s inside {ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L};
   endfunction

   function automatic logic is_frame_state(input state_t s);
      return s inside {ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L};
   endfunction

   function automatic logic [7:0] reply_byte(input tx_sel_t sel, input logic [15:0] rdata);
      case (sel)
         SEL_K:   return RSP_K;
         SEL_E:   return RSP_E;
         SEL_HI:  return rdata[15:8];
         SEL_LO:  return rdata[7:0];
         default: return RSP_E;
      endcase
   endfunction

endpackage

// File: rtl/uart_io_bridge_timeout.sv
// Inter-byte timeout: counts enabled cycles since the last clear and flags the terminal count.
module bridge_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 120000,
   parameter int unsigned TO_W           = 17
) (
   input  logic clk,
   input  logic resetq,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt_q;

   // Saturates at LAST so a stalled enable never wraps back to a fresh window.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + TO_W'(1);
      end
   end

   assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_io_bridge.sv
// Host debug bridge: parses W/R command frames from the byte UART, runs one I/O bus access
// on behalf of the host and sends the K / data / E reply back through the UART transmitter.
module uart_io_bridge
   import uart_io_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 120000,
   parameter int unsigned TO_W           = 17
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_rd,
   input  logic        tx_busy,
   output logic        tx_wr,
   output logic [7:0]  tx_data,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic        io_rd,
   output logic        io_wr,
   output logic [15:0] io_addr,
   output logic [15:0] io_dout,
   input  logic [15:0] io_din,
   output logic        frame_err
);

   state_t      state_q, state_d;
   tx_sel_t     sel_q, sel_d;
   logic        is_rd_q, is_rd_d;
   logic        run_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic        consume;
   logic        to_en;
   logic        to_expired;

   // run_q keeps rx_rd low while resetq is asserted even if buart already holds a byte.
   assign consume = run_q && rx_valid && is_rx_state(state_q);
   assign to_en   = is_frame_state(state_q);

   bridge_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_timeout (
      .clk     (clk),
      .resetq  (resetq),
      .clr     (consume || !to_en),
      .en      (to_en),
      .expired (to_expired)
   );

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      is_rd_d   = is_rd_q;
      frame_err = 1'b0;
      bus_req   = 1'b0;
      io_rd     = 1'b0;
      io_wr     = 1'b0;
      tx_wr     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (consume) begin
               if (rx_data == CMD_W) begin
                  is_rd_d = 1'b0;
                  state_d = ST_ADDR_H;
               end else if (rx_data == CMD_R) begin
                  is_rd_d = 1'b1;
                  state_d = ST_ADDR_H;
               end else begin
                  frame_err = 1'b1;
                  sel_d     = SEL_E;
                  state_d   = ST_TX;
               end
            end
         end
         ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L: begin
            if (consume) begin
               case (state_q)
                  ST_ADDR_H: state_d = ST_ADDR_L;
                  ST_ADDR_L: state_d = is_rd_q ? ST_REQ : ST_DATA_H;
                  ST_DATA_H: state_d = ST_DATA_L;
                  default:   state_d = ST_REQ;
               endcase
            end else if (to_expired) begin
               frame_err = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_REQ: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               io_rd   = is_rd_q;
               io_wr   = !is_rd_q;
               sel_d   = is_rd_q ? SEL_HI : SEL_K;
               state_d = ST_TX;
            end
         end
         ST_TX: begin
            if (!tx_busy) begin
               tx_wr   = 1'b1;
               state_d = ST_TX_GAP;
            end
         end
         ST_TX_GAP: begin
            // buart raises tx_busy one cycle after tx_wr, so tx_busy is not trusted here.
            if (sel_q == SEL_HI) begin
               sel_d   = SEL_LO;
               state_d = ST_TX;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_K;
         is_rd_q <= 1'b0;
         run_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         is_rd_q <= is_rd_d;
         run_q   <= 1'b1;
         if (consume) begin
            case (state_q)
               ST_ADDR_H: addr_q[15:8]  <= rx_data;
               ST_ADDR_L: addr_q[7:0]   <= rx_data;
               ST_DATA_H: wdata_q[15:8] <= rx_data;
               ST_DATA_L: wdata_q[7:0]  <= rx_data;
               default:   ;
            endcase
         end
         if (io_rd) begin
            rdata_q <= io_din;
         end
      end
   end

   assign rx_rd   = consume;
   assign io_addr = addr_q;
   assign io_dout = wdata_q;
   assign tx_data = tx_wr ? reply_byte(sel_q, rdata_q) : 8'h00;

endmodule

// File: tb/tb_uart_io_bridge.sv
// Bench for uart_io_bridge: buart/bus responder models plus a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_io_bridge;

   localparam int unsigned T_CYC = 200;
   localparam int unsigned T_W   = 8;

   logic        clk = 1'b0;
   logic        resetq = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_rd;
   logic        tx_busy = 1'b0;
   logic        tx_wr;
   logic [7:0]  tx_data;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] io_addr;
   logic [15:0] io_dout;
   logic [15:0] io_din;
   logic        frame_err;

   always #5 clk = ~clk;

   uart_io_bridge #(
      .TIMEOUT_CYCLES (T_CYC),
      .TO_W           (T_W)
   ) dut (
      .clk       (clk),
      .resetq    (resetq),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_rd     (rx_rd),
      .tx_busy   (tx_busy),
      .tx_wr     (tx_wr),
      .tx_data   (tx_data),
      .bus_req   (bus_req),
      .bus_gnt   (bus_gnt),
      .io_rd     (io_rd),
      .io_wr     (io_wr),
      .io_addr   (io_addr),
      .io_dout   (io_dout),
      .io_din    (io_din),
      .frame_err (frame_err)
   );

   // Responder: read data is only meaningful during the io_rd cycle.
   logic [15:0] rd_val = 16'h0000;
   assign io_din = io_rd ? rd_val : 16'hDEAD;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Environment and reference-model state.
   logic [7:0]  rx_q[$];
   logic [7:0]  tx_got[$];
   logic [7:0]  tx_exp[$];
   logic [32:0] tr_got[$];
   logic [32:0] tr_exp[$];
   int fe_cnt = 0, fe_exp = 0;
   int both_cnt = 0, nogrant_cnt = 0, req_late_cnt = 0, rd_novalid_cnt = 0;
   int overrun_cnt = 0, req_drop_cnt = 0, req_cycles = 0;
   int cyc = 0, last_rd_cyc = 0, last_fe_cyc = 0;
   int rx_hold = 0, busy_left = 0, gnt_delay = 0, gnt_wait = 0;
   logic tx_start_pend = 1'b0;
   logic prev_strobe = 1'b0;
   logic req_open = 1'b0;

   task automatic tick();
      logic pop, txw, strobe;
      @(negedge clk);
      cyc++;
      pop = rx_rd;
      if (rx_rd && !rx_valid) rd_novalid_cnt++;
      if (rx_rd) last_rd_cyc = cyc;
      if (frame_err) begin
         fe_cnt++;
         last_fe_cyc = cyc;
      end
      if (io_rd && io_wr) both_cnt++;
      strobe = io_rd || io_wr;
      if (strobe && (!bus_gnt || !bus_req)) nogrant_cnt++;
      if (io_wr) tr_got.push_back({1'b1, io_addr, io_dout});
      if (io_rd) tr_got.push_back({1'b0, io_addr, 16'h0000});
      if (prev_strobe && bus_req) req_late_cnt++;
      if (!bus_req && req_open) req_drop_cnt++;
      if (bus_req) begin
         req_open = 1'b1;
         req_cycles++;
      end
      if (strobe) req_open = 1'b0;
      prev_strobe = strobe;
      txw = tx_wr;
      if (tx_wr) begin
         tx_got.push_back(tx_data);
         if (tx_busy || tx_start_pend) overrun_cnt++;
      end
      @(posedge clk);
      #1;
      if (pop) begin
         void'(rx_q.pop_front());
         rx_hold = $urandom_range(0, 3);
      end else if (rx_hold > 0) begin
         rx_hold--;
      end
      rx_valid = (rx_q.size() > 0) && (rx_hold == 0);
      rx_data  = rx_valid ? rx_q[0] : 8'($urandom);
      if (tx_start_pend) begin
         tx_start_pend = 1'b0;
         tx_busy = 1'b1;
         busy_left = $urandom_range(2, 8);
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) tx_busy = 1'b0;
      end
      if (txw) tx_start_pend = 1'b1;
      if (bus_req) begin
         if (gnt_wait >= gnt_delay) bus_gnt = 1'b1;
         else gnt_wait++;
      end else begin
         bus_gnt = 1'b0;
         gnt_wait = 0;
      end
   endtask

   // Reference model: kind 0 = write, 1 = read, other = bad command byte.
   task automatic send_frame(input int kind, input logic [15:0] a, input logic [15:0] d,
                             input logic [7:0] bad);
      if (kind == 0) begin
         rx_q.push_back(8'h57);
         rx_q.push_back(a[15:8]);
         rx_q.push_back(a[7:0]);
         rx_q.push_back(d[15:8]);
         rx_q.push_back(d[7:0]);
         tx_exp.push_back(8'h4B);
         tr_exp.push_back({1'b1, a, d});
      end else if (kind == 1) begin
         rx_q.push_back(8'h52);
         rx_q.push_back(a[15:8]);
         rx_q.push_back(a[7:0]);
         rd_val = d;
         tx_exp.push_back(d[15:8]);
         tx_exp.push_back(d[7:0]);
         tr_exp.push_back({1'b0, a, 16'h0000});
      end else begin
         rx_q.push_back(bad);
         tx_exp.push_back(8'h45);
         fe_exp++;
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while ((tx_got.size() < tx_exp.size() || rx_q.size() > 0 || tx_busy || tx_start_pend
              || bus_req) && n < 5000) begin
         tick();
         n++;
      end
      check({tag, "_done"}, 64'(n < 5000), 64'd1);
      repeat (6) tick();
   endtask

   task automatic compare_queues(input string tag);
      check({tag, "_ntx"}, 64'(tx_got.size()), 64'(tx_exp.size()));
      check({tag, "_ntr"}, 64'(tr_got.size()), 64'(tr_exp.size()));
      while (tx_got.size() > 0 && tx_exp.size() > 0)
         check({tag, "_tx"}, 64'(tx_got.pop_front()), 64'(tx_exp.pop_front()));
      while (tr_got.size() > 0 && tr_exp.size() > 0)
         check({tag, "_tr"}, 64'(tr_got.pop_front()), 64'(tr_exp.pop_front()));
      check({tag, "_ferr"}, 64'(fe_cnt), 64'(fe_exp));
      tx_got.delete();
      tx_exp.delete();
      tr_got.delete();
      tr_exp.delete();
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({rx_rd, tx_wr, tx_data, bus_req, io_rd, io_wr, io_addr, io_dout, frame_err});
   endfunction

   initial begin
      logic [15:0] addr_tab [4];
      logic [15:0] a, d;
      logic [7:0]  bad;
      int kind, n, dly;
      addr_tab[0] = 16'h1000;
      addr_tab[1] = 16'h2000;
      addr_tab[2] = 16'h4000;
      addr_tab[3] = 16'h8000;

      // Reset with a bad byte already waiting in buart.
      rx_q.push_back(8'h41);
      rx_valid = 1'b1;
      rx_data  = 8'h41;
      repeat (3) tick();
      check("reset_outs", all_outs(), 64'h0);
      resetq = 1'b1;
      fe_exp = 1;
      tx_exp.push_back(8'h45);
      wait_done("bad_cmd");
      compare_queues("bad_cmd");

      send_frame(1, 16'h2000, 16'h5AC3, 8'h00);
      wait_done("after_bad_rd");
      compare_queues("after_bad_rd");

      send_frame(0, 16'h4000, 16'h1234, 8'h00);
      wait_done("wr_4000");
      compare_queues("wr_4000");

      send_frame(1, 16'h8000, 16'hBEEF, 8'h00);
      wait_done("rd_8000");
      compare_queues("rd_8000");

      // Truncated write frame then silence.
      rx_q.push_back(8'h57);
      rx_q.push_back(8'h10);
      repeat (T_CYC + 40) tick();
      fe_exp++;
      dly = last_fe_cyc - last_rd_cyc;
      check("timeout_delay_ok", 64'(dly >= int'(T_CYC) - 1 && dly <= int'(T_CYC) + 1), 64'd1);
      compare_queues("timeout");
      send_frame(0, 16'h2000, 16'h00AA, 8'h00);
      wait_done("after_timeout");
      compare_queues("after_timeout");

      // Grant held off for 50 cycles.
      gnt_delay = 50;
      req_cycles = 0;
      send_frame(0, 16'h1000, 16'h0041, 8'h00);
      wait_done("gnt_late");
      check("gnt_late_req_held", 64'(req_cycles >= 50), 64'd1);
      compare_queues("gnt_late");

      // Two frames back to back: the second waits in buart during access and reply.
      gnt_delay = 3;
      send_frame(0, 16'h8000, 16'hCAFE, 8'h00);
      send_frame(1, 16'h4000, 16'h0F0F, 8'h00);
      wait_done("b2b");
      compare_queues("b2b");

      for (int i = 0; i < 30; i++) begin
         kind = $urandom_range(0, 9);
         kind = (kind < 4) ? 0 : (kind < 8) ? 1 : 2;
         a = ($urandom_range(0, 1) == 0) ? addr_tab[$urandom_range(0, 3)] : 16'($urandom);
         d = 16'($urandom);
         bad = 8'($urandom);
         while (bad == 8'h57 || bad == 8'h52) bad = 8'($urandom);
         gnt_delay = $urandom_range(0, 6);
         send_frame(kind, a, d, bad);
         wait_done("rand");
         compare_queues("rand");
      end

      // Reset while buart is sending the high byte of a read reply.
      gnt_delay = 1;
      send_frame(1, 16'h8000, 16'hBEEF, 8'h00);
      n = 0;
      while (tx_got.size() == 0 && n < 2000) begin
         tick();
         n++;
      end
      check("rst_wait_hi", 64'(n < 2000), 64'd1);
      #2 resetq = 1'b0;
      #1;
      check("rst_outs_now", all_outs(), 64'h0);
      repeat (3) tick();
      check("rst_outs_held", all_outs(), 64'h0);
      resetq = 1'b1;
      repeat (300) tick();
      check("rst_tx_count", 64'(tx_got.size()), 64'd1);
      if (tx_got.size() > 0) check("rst_tx_hi", 64'(tx_got[0]), 64'hBE);
      check("rst_tr_count", 64'(tr_got.size()), 64'd1);
      tx_got.delete();
      tx_exp.delete();
      tr_got.delete();
      tr_exp.delete();
      send_frame(0, 16'h1000, 16'h7E57, 8'h00);
      wait_done("after_rst");
      compare_queues("after_rst");

      check("rd_wr_overlap", 64'(both_cnt), 64'd0);
      check("strobe_without_gnt", 64'(nogrant_cnt), 64'd0);
      check("req_after_access", 64'(req_late_cnt), 64'd0);
      check("req_dropped_early", 64'(req_drop_cnt), 64'd0);
      check("rx_rd_without_valid", 64'(rd_novalid_cnt), 64'd0);
      check("tx_overrun", 64'(overrun_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
      $fatal(1);
   end

endmodule
